// File: rtl/vdac_fade_ctrl.sv
// Frame-synchronous brightness fader and DAC mode sequencer in front of the video DAC.
// Scales 5-bit RGB by a 0..16 level that steps on vsync rises; mode changes apply at vsync.
module vdac_fade_ctrl #(
  parameter int FRAME_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             vred_in,
  input  logic [4:0]             vgrn_in,
  input  logic [4:0]             vblu_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   cfg_start,
  input  logic                   cfg_dir,
  input  logic [FRAME_CNT_W-1:0] cfg_rate,
  input  logic                   cfg_mode_wr,
  input  logic                   cfg_mode,
  output logic                   busy,
  output logic                   done,
  output logic [4:0]             level,
  output logic [4:0]             vred_raw,
  output logic [4:0]             vgrn_raw,
  output logic [4:0]             vblu_raw,
  output logic                   vdac_mode,
  output logic                   hsync_o,
  output logic                   vsync_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_vsync_d;
  logic                   r_dir_q;
  logic                   r_done;
  logic                   r_pend_valid;
  logic                   r_pend_mode;
  logic                   r_mode;
  logic [FRAME_CNT_W-1:0] r_rate_q;
  logic [FRAME_CNT_W-1:0] r_fcnt;
  logic [4:0]             r_level;
  logic [4:0]             w_level_step;
  logic [4:0]             w_run_tgt;
  logic [4:0]             w_start_tgt;
  logic                   w_tick;
  logic                   w_step;
  logic                   w_fade_end;
  logic                   w_start_go;
  logic                   w_start_noop;

  function automatic logic [4:0] scale(input logic [4:0] c, input logic [4:0] l);
    logic [8:0] p;
    p = {4'd0, c} * {4'd0, l};
    return 5'(p >> 4);
  endfunction

  assign w_tick       = vsync_in & ~r_vsync_d;
  assign w_start_tgt  = cfg_dir ? 5'd16 : 5'd0;
  assign w_run_tgt    = r_dir_q ? 5'd16 : 5'd0;
  assign w_level_step = r_dir_q ? r_level + 5'd1 : r_level - 5'd1;
  assign w_step       = (r_state == S_RUN) & w_tick & (r_fcnt == r_rate_q);
  assign w_fade_end   = w_step & (w_level_step == w_run_tgt);
  assign w_start_go   = (r_state == S_IDLE) & cfg_start & (r_level != w_start_tgt);
  assign w_start_noop = (r_state == S_IDLE) & cfg_start & (r_level == w_start_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_go) w_state_nxt = S_RUN;
      S_RUN:   if (w_fade_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_RUN);
    done      = r_done;
    level     = r_level;
    vdac_mode = r_mode;
  end

  // A start in the same cycle as a tick takes priority, so that tick is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done   <= 1'b0;
      r_dir_q  <= 1'b0;
      r_rate_q <= '0;
      r_fcnt   <= '0;
      r_level  <= 5'd16;
    end else begin
      r_done <= w_start_noop | w_fade_end;
      if (w_start_go) begin
        r_dir_q  <= cfg_dir;
        r_rate_q <= cfg_rate;
        r_fcnt   <= '0;
      end else if ((r_state == S_RUN) && w_tick) begin
        if (w_step) begin
          r_fcnt  <= '0;
          r_level <= w_level_step;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  // A write coinciding with the tick bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= 1'b0;
      r_pend_mode  <= 1'b0;
      r_pend_valid <= 1'b0;
    end else if (w_tick) begin
      if (cfg_mode_wr) begin
        r_mode <= cfg_mode;
      end else if (r_pend_valid) begin
        r_mode <= r_pend_mode;
      end
      r_pend_valid <= 1'b0;
    end else if (cfg_mode_wr) begin
      r_pend_mode  <= cfg_mode;
      r_pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      vred_raw  <= '0;
      vgrn_raw  <= '0;
      vblu_raw  <= '0;
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
    end else begin
      r_vsync_d <= vsync_in;
      vred_raw  <= scale(vred_in, r_level);
      vgrn_raw  <= scale(vgrn_in, r_level);
      vblu_raw  <= scale(vblu_in, r_level);
      hsync_o   <= hsync_in;
      vsync_o   <= vsync_in;
    end
  end

endmodule

// File: tb/tb_vdac_fade_ctrl.sv
// Scoreboard bench for vdac_fade_ctrl: a driver computes expected outputs from a
// frame-level fade model and queues them; a monitor compares every clock.
module tb_vdac_fade_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   vred_in, vgrn_in, vblu_in;
  logic         hsync_in, vsync_in;
  logic         cfg_start, cfg_dir, cfg_mode_wr, cfg_mode;
  logic [W-1:0] cfg_rate;
  logic         busy, done, vdac_mode, hsync_o, vsync_o;
  logic [4:0]   level, vred_raw, vgrn_raw, vblu_raw;

  vdac_fade_ctrl #(.FRAME_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .vred_in(vred_in), .vgrn_in(vgrn_in), .vblu_in(vblu_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_rate(cfg_rate),
    .cfg_mode_wr(cfg_mode_wr), .cfg_mode(cfg_mode),
    .busy(busy), .done(done), .level(level),
    .vred_raw(vred_raw), .vgrn_raw(vgrn_raw), .vblu_raw(vblu_raw),
    .vdac_mode(vdac_mode), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] r, g, b;
    logic       hs, vs;
    logic       busy, done;
    logic [4:0] level;
    logic       mode;
  } exp_t;

  localparam exp_t RST_EXP = '{r: 5'd0, g: 5'd0, b: 5'd0, hs: 1'b0, vs: 1'b0,
                               busy: 1'b0, done: 1'b0, level: 5'd16, mode: 1'b0};

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic driving = 1'b1;

  // Reference model: a fade is described by its start level and ticks elapsed.
  int   m_level = 16;
  logic m_busy = 1'b0, m_dir = 1'b0, m_mode = 1'b0, m_pend = 1'b0, m_pend_val = 1'b0;
  logic m_prev_vs = 1'b0;
  int   m_rate = 0, m_ticks = 0, m_start = 16;

  logic       fix_col = 1'b0;
  logic [4:0] nr = 5'd0, ng = 5'd0, nb = 5'd0;

  task automatic model_reset();
    m_level = 16; m_busy = 1'b0; m_mode = 1'b0; m_pend = 1'b0; m_prev_vs = 1'b0;
  endtask

  task automatic step(input logic rst, input logic vs, input logic st, input logic dir,
                      input logic [W-1:0] rate, input logic mw, input logic mv);
    exp_t e;
    logic hs, tick;
    int   tgt, steps;
    if (!fix_col) begin
      nr = 5'($urandom); ng = 5'($urandom); nb = 5'($urandom);
    end
    hs = 1'($urandom);
    vred_in = nr; vgrn_in = ng; vblu_in = nb;
    hsync_in = hs; vsync_in = vs;
    cfg_start = st; cfg_dir = dir; cfg_rate = rate;
    cfg_mode_wr = mw; cfg_mode = mv;
    if (rst) begin
      if (rst_n) begin
        q.delete();
        q.push_back(RST_EXP);
      end
      rst_n = 1'b0;
      model_reset();
      q.push_back(RST_EXP);
    end else begin
      rst_n = 1'b1;
      tick = vs && !m_prev_vs;
      e.r = 5'((int'(nr) * m_level) >> 4);
      e.g = 5'((int'(ng) * m_level) >> 4);
      e.b = 5'((int'(nb) * m_level) >> 4);
      e.hs = hs; e.vs = vs;
      e.done = 1'b0;
      if (!m_busy && st) begin
        tgt = dir ? 16 : 0;
        if (m_level == tgt) e.done = 1'b1;
        else begin
          m_busy = 1'b1; m_dir = dir; m_rate = int'(rate); m_ticks = 0; m_start = m_level;
        end
      end else if (m_busy && tick) begin
        m_ticks++;
        steps = m_ticks / (m_rate + 1);
        m_level = m_dir ? m_start + steps : m_start - steps;
        if (m_level == (m_dir ? 16 : 0)) begin
          m_busy = 1'b0; e.done = 1'b1;
        end
      end
      if (tick) begin
        if (mw) m_mode = mv;
        else if (m_pend) m_mode = m_pend_val;
        m_pend = 1'b0;
      end else if (mw) begin
        m_pend = 1'b1; m_pend_val = mv;
      end
      m_prev_vs = vs;
      e.busy = m_busy; e.level = 5'(m_level); e.mode = m_mode;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) step(1'b0, vs, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      idle(5, 1'b0);
      idle(2, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({vred_raw, vgrn_raw, vblu_raw, hsync_o, vsync_o} != {e.r, e.g, e.b, e.hs, e.vs}) begin
        failures++;
        $display("FAIL video t=%0t got rgb=%0d/%0d/%0d hs=%0b vs=%0b want rgb=%0d/%0d/%0d hs=%0b vs=%0b",
                 $time, vred_raw, vgrn_raw, vblu_raw, hsync_o, vsync_o, e.r, e.g, e.b, e.hs, e.vs);
      end
      checks++;
      if ({busy, done, level, vdac_mode} != {e.busy, e.done, e.level, e.mode}) begin
        failures++;
        $display("FAIL ctrl t=%0t got busy=%0b done=%0b level=%0d mode=%0b want busy=%0b done=%0b level=%0d mode=%0b",
                 $time, busy, done, level, vdac_mode, e.busy, e.done, e.level, e.mode);
      end
    end else if (driving) begin
      checks++;
      failures++;
      $display("FAIL queue t=%0t got empty scoreboard want pending expectation", $time);
    end
  end

  initial begin
    rst_n = 1'b0;
    vred_in = '0; vgrn_in = '0; vblu_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    cfg_start = 1'b0; cfg_dir = 1'b0; cfg_rate = '0; cfg_mode_wr = 1'b0; cfg_mode = 1'b0;
    q.push_back(RST_EXP);
    @(posedge clk); #1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    fix_col = 1'b1; nr = 5'd24; ng = 5'd10; nb = 5'd31;
    idle(4, 1'b0);

    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    frames(17);
    fix_col = 1'b0;

    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    frames(10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    frames(40);

    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    idle(3, 1'b0);

    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    frames(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    frames(1);
    idle(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(3, 1'b0);

    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !(m_level == 7 && m_busy); i++) frames(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    fix_col = 1'b1; nr = 5'd24; ng = 5'd10; nb = 5'd31;
    idle(3, 1'b0);
    fix_col = 1'b0;

    for (int i = 0; i < 900; i++) begin
      step(1'b0, (i % 6) >= 4, $urandom_range(0, 29) == 0, 1'($urandom),
           W'($urandom_range(0, 2)), $urandom_range(0, 9) == 0, 1'($urandom));
    end

    driving = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d leftover expectations want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vdac_fade_ctrl.md
# vdac_fade_ctrl

Frame-synchronous brightness and mode sequencer placed directly in front of the video DAC stage. It scales the 5-bit raw RGB channels by a 17-step brightness level, and steps that level up or down on vsync boundaries under CPU command, producing fade-in and fade-out effects. It also applies DAC mode changes only at a frame boundary, so a mode switch never tears mid-frame. Its outputs feed the DAC's raw colour, mode and sync inputs directly.

## Interface
- FRAME_CNT_W, default 4: width of the frames-per-step counter and of cfg_rate.
- clk  in  1  video pixel clock, the same clock as the DAC stage.
- rst_n  in  1  asynchronous, active-low reset.
- vred_in, vgrn_in, vblu_in  in  5 each  raw colour from the video pipeline.
- hsync_in, vsync_in  in  1 each  syncs from the video pipeline, synchronous to clk, active-high.
- cfg_start  in  1  single-cycle pulse that requests a fade.
- cfg_dir  in  1  fade direction, sampled with cfg_start: 1 = fade in (toward level 16), 0 = fade out (toward level 0).
- cfg_rate  in  FRAME_CNT_W  frames per step minus 1, sampled with cfg_start.
- cfg_mode_wr  in  1  single-cycle pulse that writes a pending DAC mode.
- cfg_mode  in  1  mode value, sampled with cfg_mode_wr.
- busy  out  1  high while a fade is in progress.
- done  out  1  one-cycle pulse when a fade completes.
- level  out  5  current brightness level, 0..16.
- vred_raw, vgrn_raw, vblu_raw  out  5 each  scaled colour to the DAC.
- vdac_mode  out  1  applied DAC mode.
- hsync_o, vsync_o  out  1 each  syncs delayed to align with the colour outputs.

## Operation
- Frame tick: tick = vsync_in & ~vsync_d, where vsync_d is vsync_in registered once.
- Scaling: each channel output = (in × level) >> 4.
  - The product is 9 bits wide; the result is truncated to 5 bits.
  - Level 16 gives an exact pass-through; level 0 gives 0.
- State machine with two states, IDLE and RUN.
- In IDLE, cfg_start with level ≠ target:
  - Latch dir and rate into the internal registers (rate_q).
  - Clear fcnt and enter RUN; busy = 1.
  - Target is 16 when dir = 1 and 0 when dir = 0.
- In IDLE, cfg_start with level = target: stay in IDLE; done pulses on the next cycle; busy stays 0.
- In RUN, cfg_start is ignored; the latched dir and rate are unaffected.
- In RUN, on each tick:
  - If fcnt = rate_q: set fcnt = 0 and move level one step toward the target.
  - Otherwise: fcnt = fcnt + 1.
- When level reaches the target: return to IDLE and pulse done for one cycle; busy drops in that same cycle.
- A fade holds its final level indefinitely, so the level persists after done.
- Level changes only on ticks, so it is constant within a frame.
- Mode write: cfg_mode_wr sets pend_mode = cfg_mode and pend_valid = 1.
  - On the next tick, vdac_mode takes pend_mode and pend_valid clears.
  - A later write before the tick overwrites the pending value (last write wins).
- Simultaneous events:
  - cfg_start and a tick in the same cycle: the start is accepted and the tick is not counted toward the new fade.
  - cfg_mode_wr and a tick in the same cycle: the new value is applied at that tick.
- Reset (asynchronous, also mid-fade):
  - State returns to IDLE; level = 16; fcnt = 0.
  - vdac_mode = 0; pend_valid = 0; busy = 0; done = 0.
  - All colour and sync outputs = 0; vsync_d = 0.

## Timing
- Colour and sync path latency: 1 clk.
  - Input sampled at edge k appears on the outputs after edge k.
  - hsync_o and vsync_o are delayed identically, so pixel alignment is preserved.
- Tick detection is combinational from vsync_in and vsync_d.
  - A level or mode update is registered at the same edge that samples the vsync rise.
  - The update therefore first affects the outputs for pixels sampled from the next edge onward.
  - This is the first pixel clock of vsync, i.e. during blanking.
- Steps occur every (rate_q + 1) ticks.
  - A full fade takes 16 × (rate_q + 1) ticks from the first tick after start.
- busy rises on the edge after cfg_start is sampled; done asserts on the same edge where level reaches the target.

## Test plan
- Reset passthrough: release reset, drive R = 24, G = 10, B = 31 → one cycle later vred_raw = 24, vgrn_raw = 10, vblu_raw = 31; level = 16; vdac_mode = 0.
- Fade out at rate 0: cfg_start with dir = 0, rate = 0, then 16 vsync rises → level goes 15, 14, …, 0 one step per frame; R = 24 at level 8 gives 12; done pulses once at level 0; busy high throughout.
- Fade in at rate 2: starting from level 0, cfg_start with dir = 1, rate = 2 → level increments on every third tick; done after 48 ticks; a cfg_start with dir = 0 issued mid-fade is ignored.
- No-op start: at level 16, cfg_start with dir = 1 → done pulses the next cycle, busy never rises, level stays 16.
- Mode deferral: cfg_mode_wr with mode = 1 mid-frame → vdac_mode stays 0 until the next vsync rise, then becomes 1. Two writes (1, then 0) before a tick → vdac_mode stays 0.
- Reset mid-fade: assert rst_n low at level 7 while busy → all outputs clear immediately; after release, level = 16, busy = 0, and the outputs pass colour through unscaled.
